// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selection tables, per-round shift
// amounts, fixed widths and the scheduler state type.
package des_pkg;

   localparam int unsigned KEY_W    = 64;
   localparam int unsigned HALF_W   = 28;
   localparam int unsigned SUBKEY_W = 48;

   typedef enum logic {IDLE, RUN} state_e;

   // Entries are 1-based DES bit numbers; entry 0 selects output bit 1
   localparam int unsigned PC1_TABLE [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFT_TABLE [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

endpackage

// File: rtl/des_rot28.sv
// Combinational rotate of one 28-bit key half by 1 or 2 places in either direction.
module des_rot28
   import des_pkg::*;
(
   input  logic [HALF_W:1] half,
   input  logic            dir,     // 0 = left, 1 = right
   input  logic [1:0]      amt,
   output logic [HALF_W:1] rotated
);

   always_comb begin
      rotated = half;
      unique case ({dir, amt})
         3'b001:  rotated = {half[HALF_W-1:1], half[HALF_W]};
         3'b010:  rotated = {half[HALF_W-2:1], half[HALF_W:HALF_W-1]};
         3'b101:  rotated = {half[1], half[HALF_W:2]};
         3'b110:  rotated = {half[2:1], half[HALF_W:3]};
         default: rotated = half;
      endcase
   end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: emits K1..K16 (or K16..K1 when decrypting),
// one subkey per valid/ready transfer.
module des_key_schedule
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                decrypt,
   input  logic [KEY_W:1]      key,
   output logic [SUBKEY_W:1]   subkey,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [4:1]          round,
   output logic                busy,
   output logic                done
);

   state_e             state_q, state_d;
   logic [HALF_W:1]    c_q, c_d, d_q, d_d;
   logic [HALF_W:1]    c_rot_in, d_rot_in, c_rot, d_rot;
   logic [4:1]         step_q, step_d, shift_idx;
   logic               mode_q, mode_d, done_q, done_d;
   logic               rot_dir;
   logic [1:0]         rot_amt;
   logic [2*HALF_W:1]  pc1_out, cd;
   logic               unused_parity;

   assign unused_parity = ^{key[57], key[49], key[41], key[33],
                            key[25], key[17], key[9],  key[1]};

   // Vector index 2*HALF_W+1-b holds DES bit b, so table entries map directly
   always_comb begin
      pc1_out = '0;
      for (int i = 0; i < 2 * HALF_W; i++) begin
         pc1_out[2 * HALF_W - i] = key[KEY_W + 1 - PC1_TABLE[i]];
      end
   end

   assign cd = {c_q, d_q};

   always_comb begin
      subkey = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         subkey[SUBKEY_W - i] = cd[2 * HALF_W + 1 - PC2_TABLE[i]];
      end
   end

   // In IDLE the rotators pre-rotate the fresh PC-1 halves left by 1 to form K1
   always_comb begin
      shift_idx = mode_q ? (4'd15 - step_q) : (step_q + 4'd1);
      rot_amt   = 2'(SHIFT_TABLE[shift_idx]);
      rot_dir   = mode_q;
      c_rot_in  = c_q;
      d_rot_in  = d_q;
      if (state_q == IDLE) begin
         c_rot_in = pc1_out[2*HALF_W:HALF_W+1];
         d_rot_in = pc1_out[HALF_W:1];
         rot_amt  = 2'd1;
         rot_dir  = 1'b0;
      end
   end

   des_rot28 u_rot_c (
      .half    (c_rot_in),
      .dir     (rot_dir),
      .amt     (rot_amt),
      .rotated (c_rot)
   );

   des_rot28 u_rot_d (
      .half    (d_rot_in),
      .dir     (rot_dir),
      .amt     (rot_amt),
      .rotated (d_rot)
   );

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      step_d  = step_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               c_d     = decrypt ? c_rot_in : c_rot;
               d_d     = decrypt ? d_rot_in : d_rot;
               mode_d  = decrypt;
               step_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (step_q == 4'd15) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  step_d = step_q + 4'd1;
                  c_d    = c_rot;
                  d_d    = d_rot;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         step_q  <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign subkey_valid = (state_q == RUN);
   assign busy         = (state_q == RUN);
   assign round        = mode_q ? (4'd15 - step_q) : step_q;
   assign done         = done_q;

endmodule
